// File: rtl/cache_miss_controller_if.sv
// ---------------------------------------------------------------------------
// cache_miss_controller_if
// Groups the three buses the miss controller sits between:
//   CPU port    : cpu_re/cpu_we/cpu_addr/cpu_wdata in, cpu_rdata/cpu_ready out
//   cache array : cache_re/we/addr/wdata out, cache_rdata/cache_miss in,
//                 victim_dirty/tag/line in, fill_en/tag/line out
//   main memory : mem_req/we/addr/wdata out, mem_rdata/mem_ack in
// modport master : the controller's view
// modport slave  : the view of the CPU, array and memory surrounding it
// ---------------------------------------------------------------------------
interface cache_miss_controller_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int TAG_W  = 24
);
    logic              cpu_re;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [LINE_W-1:0] cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_ready;

    logic              cache_re;
    logic              cache_we;
    logic [ADDR_W-1:0] cache_addr;
    logic [LINE_W-1:0] cache_wdata;
    logic [31:0]       cache_rdata;
    logic              cache_miss;
    logic              victim_dirty;
    logic [TAG_W-1:0]  victim_tag;
    logic [LINE_W-1:0] victim_line;
    logic              fill_en;
    logic [TAG_W-1:0]  fill_tag;
    logic [LINE_W-1:0] fill_line;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        input  cpu_re, cpu_we, cpu_addr, cpu_wdata,
        input  cache_rdata, cache_miss, victim_dirty, victim_tag, victim_line,
        input  mem_rdata, mem_ack,
        output cpu_rdata, cpu_ready,
        output cache_re, cache_we, cache_addr, cache_wdata,
        output fill_en, fill_tag, fill_line,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output cpu_re, cpu_we, cpu_addr, cpu_wdata,
        output cache_rdata, cache_miss, victim_dirty, victim_tag, victim_line,
        output mem_rdata, mem_ack,
        input  cpu_rdata, cpu_ready,
        input  cache_re, cache_we, cache_addr, cache_wdata,
        input  fill_en, fill_tag, fill_line,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache_miss_controller.sv
// ---------------------------------------------------------------------------
// cache_miss_controller
// Sequences a 2-way, 8-set, 256-bit-line data cache for one CPU port.
// Hits complete in three cycles; a miss writes back a dirty LRU victim,
// fetches the missing line, installs it and replays the original access.
//
// Ports:
//   clk    : clock, all state on the rising edge
//   reset  : asynchronous active-high, clears FSM and all registered outputs
//   bus    : cache_miss_controller_if.master (CPU, array and memory buses)
//   hit_count/miss_count/wb_count : 32-bit saturating event counters,
//            present only when CACHE_PERF_CNT_EN is defined
// ---------------------------------------------------------------------------
module cache_miss_controller #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int SET_W  = 3,
    parameter int OFF_W  = 5,
    parameter int TAG_W  = ADDR_W - SET_W - OFF_W
) (
    input  logic                            clk,
    input  logic                            reset,
    cache_miss_controller_if.master         bus
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [31:0]                     hit_count,
    output logic [31:0]                     miss_count,
    output logic [31:0]                     wb_count
`endif
);

    typedef enum logic [2:0] {IDLE, LOOKUP, COMPARE, WRITEBACK, FETCH, ALLOCATE} state_t;

    state_t            state_q, state_d;
    logic              op_we_q, op_we_d;       // latched operation: 1 = write
    logic              replay_q, replay_d;     // current lookup is a post-fill replay
    logic [31:0]       cpu_rdata_q, cpu_rdata_d;
    logic              cpu_ready_q, cpu_ready_d;
    logic              cache_re_q, cache_re_d;
    logic              cache_we_q, cache_we_d;
    logic [ADDR_W-1:0] cache_addr_q, cache_addr_d;
    logic [LINE_W-1:0] cache_wdata_q, cache_wdata_d;
    logic              fill_en_q, fill_en_d;
    logic [TAG_W-1:0]  fill_tag_q, fill_tag_d;
    logic [LINE_W-1:0] fill_line_q, fill_line_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;

    logic [TAG_W-1:0]  req_tag;
    logic [SET_W-1:0]  req_set;
    logic [ADDR_W-1:0] fetch_addr;

    assign req_tag    = cache_addr_q[ADDR_W-1 -: TAG_W];
    assign req_set    = cache_addr_q[OFF_W +: SET_W];
    assign fetch_addr = {req_tag, req_set, {OFF_W{1'b0}}};

    always_comb begin
        state_d       = state_q;
        op_we_d       = op_we_q;
        replay_d      = replay_q;
        cpu_rdata_d   = cpu_rdata_q;
        cpu_ready_d   = 1'b0;
        cache_re_d    = 1'b0;
        cache_we_d    = 1'b0;
        cache_addr_d  = cache_addr_q;
        cache_wdata_d = cache_wdata_q;
        fill_en_d     = 1'b0;
        fill_tag_d    = fill_tag_q;
        fill_line_d   = fill_line_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;

        case (state_q)
            IDLE: begin
                // While cpu_ready is high the CPU is still holding the request
                // that just completed; only a request held beyond it is new.
                if ((bus.cpu_re || bus.cpu_we) && !cpu_ready_q) begin
                    op_we_d       = !bus.cpu_re;    // read wins when both set
                    replay_d      = 1'b0;
                    cache_addr_d  = bus.cpu_addr;
                    cache_wdata_d = bus.cpu_wdata;
                    // Strobe is registered on entry so it is high for exactly
                    // the LOOKUP cycle.
                    cache_re_d    = bus.cpu_re;
                    cache_we_d    = !bus.cpu_re;
                    state_d       = LOOKUP;
                end
            end
            LOOKUP: begin
                state_d = COMPARE;
            end
            COMPARE: begin
                if (!bus.cache_miss) begin
                    if (!op_we_q) cpu_rdata_d = bus.cache_rdata;
                    cpu_ready_d = 1'b1;
                    state_d     = IDLE;
                end else if (bus.victim_dirty) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {bus.victim_tag, req_set, {OFF_W{1'b0}}};
                    mem_wdata_d = bus.victim_line;
                    state_d     = WRITEBACK;
                end else begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = fetch_addr;
                    state_d     = FETCH;
                end
            end
            WRITEBACK: begin
                if (bus.mem_ack) begin
                    // Request drops for one cycle so the fetch is seen as a
                    // separate memory transaction.
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = FETCH;
                end
            end
            FETCH: begin
                if (!mem_req_q) begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = fetch_addr;
                end else if (bus.mem_ack) begin
                    mem_req_d   = 1'b0;
                    fill_line_d = bus.mem_rdata;
                    fill_tag_d  = req_tag;
                    fill_en_d   = 1'b1;
                    state_d     = ALLOCATE;
                end
            end
            ALLOCATE: begin
                replay_d   = 1'b1;
                cache_re_d = !op_we_q;
                cache_we_d = op_we_q;
                state_d    = LOOKUP;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            op_we_q       <= 1'b0;
            replay_q      <= 1'b0;
            cpu_rdata_q   <= '0;
            cpu_ready_q   <= 1'b0;
            cache_re_q    <= 1'b0;
            cache_we_q    <= 1'b0;
            cache_addr_q  <= '0;
            cache_wdata_q <= '0;
            fill_en_q     <= 1'b0;
            fill_tag_q    <= '0;
            fill_line_q   <= '0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            op_we_q       <= op_we_d;
            replay_q      <= replay_d;
            cpu_rdata_q   <= cpu_rdata_d;
            cpu_ready_q   <= cpu_ready_d;
            cache_re_q    <= cache_re_d;
            cache_we_q    <= cache_we_d;
            cache_addr_q  <= cache_addr_d;
            cache_wdata_q <= cache_wdata_d;
            fill_en_q     <= fill_en_d;
            fill_tag_q    <= fill_tag_d;
            fill_line_q   <= fill_line_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
        end
    end

    assign bus.cpu_rdata   = cpu_rdata_q;
    assign bus.cpu_ready   = cpu_ready_q;
    assign bus.cache_re    = cache_re_q;
    assign bus.cache_we    = cache_we_q;
    assign bus.cache_addr  = cache_addr_q;
    assign bus.cache_wdata = cache_wdata_q;
    assign bus.fill_en     = fill_en_q;
    assign bus.fill_tag    = fill_tag_q;
    assign bus.fill_line   = fill_line_q;
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;

`ifdef CACHE_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;
    logic [31:0] wb_count_q, wb_count_d;

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        wb_count_d   = wb_count_q;
        // Only first lookups are counted; replays after a fill are not.
        if (state_q == COMPARE && !replay_q) begin
            if (bus.cache_miss) miss_count_d = sat_inc(miss_count_q);
            else                hit_count_d  = sat_inc(hit_count_q);
        end
        if (state_q == WRITEBACK && bus.mem_ack) wb_count_d = sat_inc(wb_count_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
            wb_count_q   <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
            wb_count_q   <= wb_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
    assign wb_count   = wb_count_q;
`endif

endmodule
